// File: rtl/data_buffer_pkg.sv
// data_buffer_pkg: types and constants shared by the RX and TX endpoint buffers
package data_buffer_pkg;
  typedef enum logic [2:0] {HSIZE_BYTE = 3'd0, HSIZE_HALF = 3'd1, HSIZE_WORD = 3'd2} hsize_t;
  localparam int BUF_DEPTH = 64;
  localparam int BUF_OCC_W = 7;
  function automatic logic [2:0] hsize_bytes(input logic [2:0] hsize);
    return hsize == HSIZE_BYTE ? 3'd1 : hsize == HSIZE_HALF ? 3'd2 : hsize == HSIZE_WORD ? 3'd4 : 3'd0;
  endfunction
endpackage

// File: rtl/data_buffer_rx_if.sv
// data_buffer_rx_if: USB RX push side and AHB pop side of the RX endpoint buffer
interface data_buffer_rx_if import data_buffer_pkg::*; #(parameter int OCC_W = BUF_OCC_W);
  logic store_rx_packet_data;
  logic [7:0] rx_packet_data;
  logic get_rx_data;
  logic [2:0] hsize;
  logic clear;
  logic flush;
  logic [31:0] rx_data;
  logic [OCC_W-1:0] buffer_occupancy;
  logic overrun;
  logic underrun;
  modport master (output store_rx_packet_data, rx_packet_data, get_rx_data, hsize, clear, flush,
                  input rx_data, buffer_occupancy, overrun, underrun);
  modport slave (input store_rx_packet_data, rx_packet_data, get_rx_data, hsize, clear, flush,
                 output rx_data, buffer_occupancy, overrun, underrun);
endinterface

// File: rtl/byte_fifo_mem.sv
// byte_fifo_mem: byte register array with one write port and a wrapped 4-byte read window
module byte_fifo_mem #(
  parameter int DEPTH = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  for (genvar i = 0; i < 4; i++) begin : g_rd
    assign rdata[8*i +: 8] = mem[raddr + ADDR_W'(i)];
  end
endmodule

// File: rtl/data_buffer_rx.sv
// data_buffer_rx: 64-byte RX FIFO, byte pushes from USB, 1/2/4-byte little-endian pops for AHB
module data_buffer_rx import data_buffer_pkg::*; #(
  parameter int DEPTH = BUF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int OCC_W = ADDR_W + 1
) (
  input logic clk,
  input logic n_rst,
  data_buffer_rx_if.slave bus
);
  logic [ADDR_W-1:0] rptr, wptr;
  logic [OCC_W-1:0] occ;
  logic [31:0] window, masked, data_q;
  logic [2:0] n;
  logic push_ok, pop_ok, full, wipe, ovr_q, und_q;
  assign n = hsize_bytes(bus.hsize);
  assign full = occ == OCC_W'(DEPTH);
  assign push_ok = bus.store_rx_packet_data && !full;
  assign pop_ok = bus.get_rx_data && n != 3'd0 && OCC_W'(n) <= occ;
  assign wipe = bus.clear || bus.flush;
  assign masked = n == 3'd1 ? {24'b0, window[7:0]} : n == 3'd2 ? {16'b0, window[15:0]} : window;
  byte_fifo_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk(clk), .we(push_ok && !wipe), .waddr(wptr), .wdata(bus.rx_packet_data),
    .raddr(rptr), .rdata(window)
  );
  // clear/flush win over any push or pop in the same cycle and suppress both pulses
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      rptr <= '0;
      wptr <= '0;
      occ <= '0;
      data_q <= '0;
      ovr_q <= 1'b0;
      und_q <= 1'b0;
    end else if (wipe) begin
      rptr <= '0;
      wptr <= '0;
      occ <= '0;
      data_q <= bus.clear ? '0 : data_q;
      ovr_q <= 1'b0;
      und_q <= 1'b0;
    end else begin
      wptr <= wptr + ADDR_W'(push_ok);
      rptr <= pop_ok ? rptr + ADDR_W'(n) : rptr;
      occ <= occ + OCC_W'(push_ok) - (pop_ok ? OCC_W'(n) : '0);
      data_q <= pop_ok ? masked : data_q;
      ovr_q <= bus.store_rx_packet_data && full;
      und_q <= bus.get_rx_data && !pop_ok;
    end
  assign bus.rx_data = data_q;
  assign bus.buffer_occupancy = occ;
  assign bus.overrun = ovr_q;
  assign bus.underrun = und_q;
endmodule
